// File: rtl/core_dispatch_wide_pkg.sv
// core_dispatch_wide_pkg: shared decode types, register constants and RAW helpers for the dispatch stage
package core_dispatch_wide_pkg;
    localparam int NUM_REGS = 16;

    typedef logic [3:0]  reg_num;
    typedef logic [31:0] word;
    typedef logic [15:0] hword;

    typedef struct packed {
        logic alu;
        logic mul;
        logic ldst;
        logic branch;
    } insn_ctrl;

    typedef struct packed {
        insn_ctrl ctrl;
        reg_num   rd;
        reg_num   ra;
        reg_num   rb;
        logic     writes_rd;
        logic     uses_ra;
        logic     uses_rb;
    } insn_decode;

    typedef struct packed {
        insn_decode dec;
        logic       valid;
    } dispatch_slot_t;

    // True when an enabled operand register has a pending write in the given mask.
    function automatic logic raw_hit(logic en, reg_num r, logic [NUM_REGS-1:0] mask);
        return en && mask[r];
    endfunction

    // One-hot destination mask of an instruction, empty if it writes nothing.
    function automatic logic [NUM_REGS-1:0] rd_bit(insn_decode d);
        logic [NUM_REGS-1:0] m;
        m       = '0;
        m[d.rd] = d.writes_rd;
        return m;
    endfunction
endpackage

// File: rtl/core_dispatch_wide_hazards.sv
// core_dispatch_wide_hazards: combinational per-slot dispatch decision (RAW/WAW, unit limits, branch, stall)
module core_dispatch_wide_hazards
    import core_dispatch_wide_pkg::*;
#(
    parameter  int WIDTH = 2,
    localparam int SW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  dispatch_slot_t [WIDTH-1:0] i_slots,
    input  logic [NUM_REGS-1:0]        i_busy_mask,
    input  logic                       i_branch_stall,
    output logic [WIDTH-1:0]           o_dispatch,
    output logic [WIDTH-1:0]           o_alu,
    output logic [SW-1:0]              o_single_slot
);
    logic                w_ok;
    logic                w_mul;
    logic                w_ldst;
    logic                w_br;
    logic                w_found;
    logic [NUM_REGS-1:0] w_wr;
    insn_decode          w_d;

    // Walk slots oldest first; once a slot blocks, w_ok stays low so every younger slot blocks too.
    // When several single-unit ops dispatch together, the oldest one owns dec_single/sel_slot.
    always_comb begin
        w_ok          = !i_branch_stall;
        w_mul         = 1'b0;
        w_ldst        = 1'b0;
        w_br          = 1'b0;
        w_found       = 1'b0;
        w_wr          = '0;
        w_d           = '0;
        o_dispatch    = '0;
        o_alu         = '0;
        o_single_slot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_d  = i_slots[i].dec;
            w_ok = w_ok && i_slots[i].valid
                   && !raw_hit(w_d.uses_ra, w_d.ra, i_busy_mask | w_wr)
                   && !raw_hit(w_d.uses_rb, w_d.rb, i_busy_mask | w_wr)
                   && !raw_hit(w_d.writes_rd, w_d.rd, w_wr)
                   && !(w_d.ctrl.mul && w_mul) && !(w_d.ctrl.ldst && w_ldst)
                   && !(w_d.ctrl.branch && w_br) && !w_br;
            o_dispatch[i] = w_ok;
            o_alu[i]      = w_ok && w_d.ctrl.alu;
            if (w_ok) begin
                w_wr   = w_wr | rd_bit(w_d);
                w_mul  = w_mul | w_d.ctrl.mul;
                w_ldst = w_ldst | w_d.ctrl.ldst;
                w_br   = w_br | w_d.ctrl.branch;
                if (!w_found && (w_d.ctrl.mul || w_d.ctrl.ldst || w_d.ctrl.branch)) begin
                    o_single_slot = SW'(i);
                    w_found       = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/core_dispatch_wide.sv
// core_dispatch_wide: in-order multi-issue dispatch queue; optional perf counters via CORE_DISPATCH_PERF_EN
module core_dispatch_wide
    import core_dispatch_wide_pkg::*;
#(
    parameter  int WIDTH  = 2,
    parameter  int QDEPTH = 4,
    localparam int CW     = $clog2(WIDTH + 1),
    localparam int PW     = $clog2(QDEPTH),
    localparam int OW     = $clog2(QDEPTH + 1),
    localparam int SW     = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    input  logic [CW-1:0]                in_count,
    input  insn_decode [WIDTH-1:0]       in_dec,
    output logic                         in_ready,
    input  logic [NUM_REGS-1:0]          busy_mask,
    input  logic                         branch_stall,
    input  logic                         flush,
    output reg_num [2*WIDTH-1:0]         rd_r,
    input  word [2*WIDTH-1:0]            rd_value,
    output logic [WIDTH-1:0]             start_alu,
    output logic                         start_mul,
    output logic                         start_ldst,
    output logic                         start_branch,
    output insn_decode [WIDTH-1:0]       dec_alu,
    output insn_decode                   dec_single,
    output word                          single_rd_value_a,
    output word                          single_rd_value_b,
    output logic [NUM_REGS-1:0]          issue_wr_mask,
    output logic [CW-1:0]                dispatch_count
`ifdef CORE_DISPATCH_PERF_EN
    ,
    output logic [31:0]                  perf_dispatched,
    output logic [31:0]                  perf_stall_cycles
`endif
);
    insn_decode                r_q [QDEPTH];
    logic [PW-1:0]             r_head;
    logic [PW-1:0]             r_tail;
    logic [OW-1:0]             r_count;
    logic [SW-1:0]             r_sel;
    dispatch_slot_t [WIDTH-1:0] w_slots;
    logic [WIDTH-1:0]          w_disp;
    logic [WIDTH-1:0]          w_alu;
    logic [WIDTH-1:0]          w_go;
    logic [SW-1:0]             w_sel;
    logic                      w_push;
    logic [CW-1:0]             w_push_n;

    // Present the oldest WIDTH queue entries as the dispatch window and drive read ports from it.
    always_comb begin
        w_slots = '0;
        rd_r    = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_slots[i].dec   = r_q[r_head + PW'(i)];
            w_slots[i].valid = OW'(i) < r_count;
            rd_r[2*i]        = w_slots[i].dec.ra;
            rd_r[2*i+1]      = w_slots[i].dec.rb;
        end
    end

    core_dispatch_wide_hazards #(.WIDTH(WIDTH)) u_hazards (
        .i_slots        (w_slots),
        .i_busy_mask    (busy_mask),
        .i_branch_stall (branch_stall),
        .o_dispatch     (w_disp),
        .o_alu          (w_alu),
        .o_single_slot  (w_sel)
    );

    // Flush suppresses dispatch; count the dispatched prefix and collect its destination registers.
    always_comb begin
        w_go           = flush ? '0 : w_disp;
        dispatch_count = '0;
        issue_wr_mask  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dispatch_count = w_go[i] ? dispatch_count + CW'(1) : dispatch_count;
            issue_wr_mask  = w_go[i] ? issue_wr_mask | rd_bit(w_slots[i].dec) : issue_wr_mask;
        end
        in_ready = (OW'(QDEPTH) - r_count) >= OW'(WIDTH);
        w_push   = in_valid && in_ready && !flush;
        w_push_n = w_push ? in_count : '0;
    end

    // Queue pointers and occupancy; flush empties the queue ahead of any push or pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PW'(dispatch_count);
            r_tail  <= r_tail + PW'(w_push_n);
            r_count <= r_count + OW'(w_push_n) - OW'(dispatch_count);
        end
    end

    // Queue storage needs no reset; occupancy alone decides which entries are live.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WIDTH; k++)
            if (w_push && CW'(k) < in_count)
                r_q[r_tail + PW'(k)] <= in_dec[k];
    end

    // Unit start pulses and the single-unit slot index, one cycle after the dispatch decision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_alu    <= '0;
            start_mul    <= 1'b0;
            start_ldst   <= 1'b0;
            start_branch <= 1'b0;
            r_sel        <= '0;
        end else begin
            start_alu    <= flush ? '0 : w_alu;
            start_mul    <= 1'b0;
            start_ldst   <= 1'b0;
            start_branch <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                if (w_go[i] && w_slots[i].dec.ctrl.mul)    start_mul    <= 1'b1;
                if (w_go[i] && w_slots[i].dec.ctrl.ldst)   start_ldst   <= 1'b1;
                if (w_go[i] && w_slots[i].dec.ctrl.branch) start_branch <= 1'b1;
            end
            r_sel <= w_sel;
        end
    end

    // Decode payloads travel alongside the starts and are qualified by them, so they carry no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < WIDTH; i++)
            dec_alu[i] <= w_slots[i].dec;
        dec_single <= w_slots[w_sel].dec;
    end

    assign single_rd_value_a = rd_value[{r_sel, 1'b0}];
    assign single_rd_value_b = rd_value[{r_sel, 1'b1}];

`ifdef CORE_DISPATCH_PERF_EN
    // Free-running dispatch and stall counters; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_dispatched   <= '0;
            perf_stall_cycles <= '0;
        end else begin
            perf_dispatched   <= perf_dispatched + 32'(dispatch_count);
            perf_stall_cycles <= perf_stall_cycles + 32'(r_count != '0 && dispatch_count == '0);
        end
    end
`endif
endmodule

// File: tb/tb_core_dispatch_wide.sv
// tb_core_dispatch_wide: directed and random checks of core_dispatch_wide against a queue-based model
module tb_core_dispatch_wide;
    import core_dispatch_wide_pkg::*;

    localparam int WIDTH  = 2;
    localparam int QDEPTH = 4;
    localparam logic [3:0] ALU = 4'b1000, MUL = 4'b0100, LDST = 4'b0010, BR = 4'b0001;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   in_valid = 1'b0;
    logic [1:0]             in_count = '0;
    insn_decode [WIDTH-1:0] in_dec = '0;
    logic                   in_ready;
    logic [15:0]            busy_mask = '0;
    logic                   branch_stall = 1'b0;
    logic                   flush = 1'b0;
    reg_num [2*WIDTH-1:0]   rd_r;
    word [2*WIDTH-1:0]      rd_value = '0;
    logic [WIDTH-1:0]       start_alu;
    logic                   start_mul, start_ldst, start_branch;
    insn_decode [WIDTH-1:0] dec_alu;
    insn_decode             dec_single;
    word                    single_rd_value_a, single_rd_value_b;
    logic [15:0]            issue_wr_mask;
    logic [1:0]             dispatch_count;
`ifdef CORE_DISPATCH_PERF_EN
    logic [31:0]            perf_dispatched, perf_stall_cycles;
`endif

    always #5 clk = ~clk;

    core_dispatch_wide #(.WIDTH(WIDTH), .QDEPTH(QDEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count), .in_dec(in_dec),
        .in_ready(in_ready), .busy_mask(busy_mask), .branch_stall(branch_stall), .flush(flush),
        .rd_r(rd_r), .rd_value(rd_value), .start_alu(start_alu), .start_mul(start_mul),
        .start_ldst(start_ldst), .start_branch(start_branch), .dec_alu(dec_alu),
        .dec_single(dec_single), .single_rd_value_a(single_rd_value_a),
        .single_rd_value_b(single_rd_value_b), .issue_wr_mask(issue_wr_mask),
        .dispatch_count(dispatch_count)
`ifdef CORE_DISPATCH_PERF_EN
        , .perf_dispatched(perf_dispatched), .perf_stall_cycles(perf_stall_cycles)
`endif
    );

    insn_decode  mq[$];
    word         regs[16];
    int          passed = 0, total = 0, fails = 0;
    int          obs_n;
    logic        obs_ready;
    int          sum_disp = 0;
    logic [31:0] m_disp = 0, m_stall = 0;
    insn_decode  a0, a1;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic insn_decode mk(logic [3:0] c, reg_num rd, reg_num ra, reg_num rb,
                                      logic w, logic ua, logic ub);
        insn_decode d;
        d.ctrl = c; d.rd = rd; d.ra = ra; d.rb = rb;
        d.writes_rd = w; d.uses_ra = ua; d.uses_rb = ub;
        return d;
    endfunction

    function automatic insn_decode rnd();
        int u;
        logic [3:0] c;
        u = $urandom_range(0, 5);
        c = (u < 3) ? ALU : (u == 3) ? MUL : (u == 4) ? LDST : BR;
        return mk(c, 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)), 4'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endfunction

    // Pairwise rule check: a slot goes only if every older slot went and none of them conflicts with it.
    function automatic int model_n();
        int n;
        bit blk;
        insn_decode d, o;
        n = 0;
        if (branch_stall) return 0;
        for (int i = 0; i < WIDTH && i < mq.size(); i++) begin
            d   = mq[i];
            blk = (d.uses_ra && busy_mask[d.ra]) || (d.uses_rb && busy_mask[d.rb]);
            for (int j = 0; j < i; j++) begin
                o = mq[j];
                if (o.writes_rd && ((d.uses_ra && d.ra == o.rd) || (d.uses_rb && d.rb == o.rd)
                                    || (d.writes_rd && d.rd == o.rd))) blk = 1;
                if ((o.ctrl.mul && d.ctrl.mul) || (o.ctrl.ldst && d.ctrl.ldst) || o.ctrl.branch) blk = 1;
            end
            if (blk) break;
            n++;
        end
        return n;
    endfunction

    task automatic drive(logic v, logic [1:0] cnt, insn_decode d0, insn_decode d1);
        in_valid = v; in_count = cnt; in_dec[0] = d0; in_dec[1] = d1;
    endtask

    // One clock: check combinational outputs at negedge, advance model at posedge, check registered outputs after.
    task automatic step();
        int n, sel;
        bit any_single, emul, eldst, ebr, rdy;
        logic [15:0] wm;
        logic [WIDTH-1:0] ealu;
        insn_decode win[WIDTH];
        word rdv[2*WIDTH];
        @(negedge clk);
        n   = flush ? 0 : model_n();
        rdy = (QDEPTH - mq.size()) >= WIDTH;
        wm = '0; ealu = '0; emul = 0; eldst = 0; ebr = 0; sel = 0; any_single = 0;
        for (int i = 0; i < WIDTH; i++) win[i] = '0;
        for (int i = 0; i < n; i++) begin
            win[i] = mq[i];
            if (mq[i].writes_rd) wm[mq[i].rd] = 1'b1;
            ealu[i] = mq[i].ctrl.alu;
            emul  |= mq[i].ctrl.mul;
            eldst |= mq[i].ctrl.ldst;
            ebr   |= mq[i].ctrl.branch;
            if (!any_single && (mq[i].ctrl.mul || mq[i].ctrl.ldst || mq[i].ctrl.branch)) begin
                sel = i; any_single = 1;
            end
        end
        chk("dispatch_count", dispatch_count, n);
        chk("issue_wr_mask", issue_wr_mask, wm);
        chk("in_ready", in_ready, rdy);
        for (int i = 0; i < WIDTH && i < mq.size(); i++) begin
            chk("rd_r_a", rd_r[2*i], mq[i].ra);
            chk("rd_r_b", rd_r[2*i+1], mq[i].rb);
        end
        obs_n = dispatch_count;
        obs_ready = in_ready;
        sum_disp += int'(dispatch_count);
        for (int k = 0; k < 2*WIDTH; k++) rdv[k] = regs[rd_r[k]];
        m_disp += 32'(n);
        if (mq.size() > 0 && n == 0) m_stall++;
        @(posedge clk);
        if (flush) mq.delete();
        else begin
            repeat (n) void'(mq.pop_front());
            if (in_valid && rdy) for (int k = 0; k < int'(in_count); k++) mq.push_back(in_dec[k]);
        end
        for (int k = 0; k < 2*WIDTH; k++) rd_value[k] = rdv[k];
        #1;
        chk("start_alu", start_alu, ealu);
        chk("start_mul", start_mul, emul);
        chk("start_ldst", start_ldst, eldst);
        chk("start_branch", start_branch, ebr);
        for (int i = 0; i < WIDTH; i++) if (ealu[i]) chk("dec_alu", dec_alu[i], win[i]);
        if (any_single) begin
            chk("dec_single", dec_single, win[sel]);
            chk("single_a", single_rd_value_a, regs[win[sel].ra]);
            chk("single_b", single_rd_value_b, regs[win[sel].rb]);
        end
`ifdef CORE_DISPATCH_PERF_EN
        chk("perf_dispatched", perf_dispatched, m_disp);
        chk("perf_stall", perf_stall_cycles, m_stall);
`endif
    endtask

    task automatic idle();
        drive(0, 0, '0, '0);
        busy_mask = '0; branch_stall = 0; flush = 0;
    endtask

    initial begin
        for (int r = 0; r < 16; r++) regs[r] = $urandom;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_start_alu", start_alu, 0);
        chk("rst_starts", {start_mul, start_ldst, start_branch}, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_dispatch", dispatch_count, 0);
`ifdef CORE_DISPATCH_PERF_EN
        chk("rst_perf", {perf_dispatched, perf_stall_cycles}, 0);
`endif
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Two independent ALU ops dispatch together.
        drive(1, 2, mk(ALU, 1, 2, 3, 1, 1, 1), mk(ALU, 4, 5, 6, 1, 1, 1)); step();
        idle(); step();
        chk("s1_count", obs_n, 2);
        chk("s1_alu", start_alu, 2'b11);
        chk("s1_mul", start_mul, 0);

        // Two muls serialise through the single mul unit.
        a0 = mk(MUL, 7, 1, 2, 1, 1, 1); a1 = mk(MUL, 8, 3, 4, 1, 1, 1);
        drive(1, 2, a0, a1); step();
        idle(); step();
        chk("s2_count0", obs_n, 1);
        chk("s2_mul0", start_mul, 1);
        chk("s2_dec0", dec_single, a0);
        step();
        chk("s2_count1", obs_n, 1);
        chk("s2_mul1", start_mul, 1);
        chk("s2_dec1", dec_single, a1);
        chk("s2_opa", single_rd_value_a, regs[3]);

        // Intra-group RAW, then scoreboard RAW holding slot 1 for two cycles.
        drive(1, 2, mk(ALU, 3, 1, 2, 1, 1, 1), mk(ALU, 5, 3, 4, 1, 1, 1)); step();
        idle(); step();
        chk("s3_first", obs_n, 1);
        busy_mask = 16'h0008; step();
        chk("s3_stall0", obs_n, 0);
        step();
        chk("s3_stall1", obs_n, 0);
        busy_mask = '0; step();
        chk("s3_go", obs_n, 1);

        // ldst behind ALU: both go, operand steered from slot 1 read port.
        drive(1, 2, mk(ALU, 1, 2, 3, 1, 1, 1), mk(LDST, 9, 5, 6, 1, 1, 1)); step();
        idle(); step();
        chk("s4_alu", start_alu, 2'b01);
        chk("s4_ldst", start_ldst, 1);
        chk("s4_opa", single_rd_value_a, regs[5]);

        // Fill under branch_stall, then flush with a bundle offered.
        branch_stall = 1;
        drive(1, 2, mk(ALU, 1, 2, 3, 1, 1, 1), mk(ALU, 4, 5, 6, 1, 1, 1));
        step(); chk("s5_ready0", obs_ready, 1);
        step(); chk("s5_ready1", obs_ready, 1);
        step(); chk("s5_full", obs_ready, 0);
        flush = 1; step();
        chk("s5_flush_alu", start_alu, 0);
        idle(); step();
        chk("s5_empty_ready", obs_ready, 1);
        chk("s5_empty_count", obs_n, 0);

        // Random traffic.
        repeat (300) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), rnd(), rnd());
            busy_mask    = 16'($urandom & $urandom & $urandom);
            branch_stall = ($urandom_range(0, 7) == 0);
            flush        = ($urandom_range(0, 19) == 0);
            step();
        end

        // Asynchronous reset between edges clears everything at once.
        idle();
        @(posedge clk); #2;
        rst_n = 0; #1;
        chk("mid_rst_alu", start_alu, 0);
        chk("mid_rst_starts", {start_mul, start_ldst, start_branch}, 0);
        chk("mid_rst_ready", in_ready, 1);
        chk("mid_rst_count", dispatch_count, 0);
        mq.delete(); m_disp = 0; m_stall = 0; sum_disp = 0;
        @(negedge clk); rst_n = 1;
        @(posedge clk); #1;

        // Ten cycles of a full pipe with three branch stalls.
        for (int c = 1; c <= 10; c++) begin
            drive(1, 2, mk(ALU, 1, 2, 3, 1, 1, 1), mk(ALU, 4, 5, 6, 1, 1, 1));
            branch_stall = (c == 3 || c == 5 || c == 7);
            step();
        end
        idle();
`ifdef CORE_DISPATCH_PERF_EN
        chk("perf_stall_3", perf_stall_cycles, 3);
        chk("perf_sum", perf_dispatched, sum_disp);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
